mux2_rr_arbiter: RTL
====================

Name: mux2_rr_arbiter

Overview:
- Shares one 2:1 data mux between two valid/ready requesters using round-robin arbitration with bounded bursts.
- Drives the mux select line from its grant state.
- Registers the selected beat into a one-entry output stage with valid/ready handshake.
- Sits in front of any consumer that previously took a hard-wired mux; requester 1 maps to the select-high input, requester 0 to the select-low input.

Parameters:
- WIDTH, 8, data width of each requester and of the output.
- MAX_BURST, 4, maximum beats one requester may transfer back-to-back while the other is waiting; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req0_valid  input  1  requester 0 has a beat
- req0_data  input  WIDTH  requester 0 beat (mux select-low input)
- req0_ready  output  1  requester 0 beat accepted this cycle when valid
- req1_valid  input  1  requester 1 has a beat
- req1_data  input  WIDTH  requester 1 beat (mux select-high input)
- req1_ready  output  1  requester 1 beat accepted this cycle when valid
- sel  output  1  mux select; 1 = requester 1
- grant  output  2  one-hot current grant; 00 in IDLE
- out_valid  output  1  output register holds a beat
- out_data  output  WIDTH  output beat
- out_ready  input  1  consumer accepts out_data this cycle

Behaviour:
- Reset: asynchronous, active-high, and overrides everything.
  - state=IDLE, sel=0, grant=00, out_valid=0, out_data=0, beat count=0.
  - last_grant=1, so requester 0 wins the first arbitration.
  - A beat held in the output register is dropped; reset may be asserted mid-burst.
- States: IDLE, GRANT0, GRANT1. All outputs are registered or decoded from registers only.
  - sel=1 only in GRANT1.
  - grant=01 in GRANT0, 10 in GRANT1.
- Output stage can load when (!out_valid || out_ready).
- reqN_ready = (state==GRANTN) && load_ok.
  - ready never depends on reqN_valid.
  - The non-granted requester's ready is always 0.
- Transfer: reqN_valid && reqN_ready.
  - At that edge, out_data <= selected data (sel ? req1_data : req0_data), out_valid <= 1.
- Output drain: out_valid && out_ready with no new transfer clears out_valid at the edge.
  - Simultaneous drain and load keeps out_valid=1 with the new data (full throughput, 1 beat/cycle).
- Latency: a beat accepted at edge k is on out_data from edge k until the consumer accepts it.
- IDLE transitions:
  - Only one valid: grant that requester.
  - Both valid: grant the one not equal to last_grant.
  - IDLE costs one bubble cycle (no ready asserted in IDLE).
- GRANTN transitions, evaluated each edge in priority order:
  1. reqN_valid=0 and other valid=1: go to GRANT(other), count=0, last_grant=N.
  2. reqN_valid=0 and other valid=0: go to IDLE, last_grant=N.
  3. Transfer occurs and count+1==MAX_BURST and other valid=1: go to GRANT(other), count=0, last_grant=N (zero-bubble switch).
  4. Transfer occurs otherwise: count <= count+1, saturating at MAX_BURST; stay in GRANTN.
  5. No transfer (consumer stall) and reqN_valid=1: hold state and count.
- Burst limit applies only when the other requester is waiting. A lone requester streams indefinitely, with count saturated.
  - If the other raises valid while count is saturated, the switch occurs after the next transfer.
- MAX_BURST=1 with both requesters continuously valid gives strict alternation 0,1,0,1.
- Requesters must hold data stable while valid && !ready; the arbiter does not check this.
- Count register width is 8 bits.

Test Plan:
- Reset then only req0_valid=1, data 0x11,0x12,0x13, out_ready=1: one IDLE bubble, then out_data 0x11,0x12,0x13 on consecutive cycles; sel=0, grant=01.
- Both valid continuously from reset, MAX_BURST=4, out_ready=1: output order is 4 beats req0, 4 beats req1, 4 beats req0; no bubble at switches; sel toggles on switch edges.
- Both valid, MAX_BURST=1: output alternates req0,req1,req0,req1; req0 first after reset.
- GRANT0 streaming, out_ready held 0 for 3 cycles: out_valid stays 1, out_data frozen, req0_ready=0, count unchanged; on release, flow resumes with no lost or duplicated beat.
- req1 bursting, req1_valid drops with req0_valid=0: next edge enters IDLE, grant=00; then req0_valid=1 yields GRANT0 one cycle later.
- rst pulsed mid-burst with out_valid=1: out_valid, sel and grant are 0 immediately (asynchronously); after release with both valid, req0 wins.

Source files
------------

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter that shares one 2:1 data mux between two valid/ready requesters,
// with a bounded burst length and a one-entry registered output stage.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sel,
  output logic [1:0]       grant,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

  logic [1:0]       state_q, state_d;
  logic             lastGrant_q, lastGrant_d;
  logic [7:0]       count_q, count_d;
  logic             outValid_q;
  logic [WIDTH-1:0] outData_q;

  logic             loadOk;
  logic             xfer;
  logic             isOne;
  logic             mineValid;
  logic             otherValid;
  logic [1:0]       otherState;
  logic [8:0]       countInc;

  assign loadOk     = !outValid_q || out_ready;
  assign req0_ready = (state_q == GRANT0) && loadOk;
  assign req1_ready = (state_q == GRANT1) && loadOk;
  assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign isOne      = (state_q == GRANT1);
  assign mineValid  = isOne ? req1_valid : req0_valid;
  assign otherValid = isOne ? req0_valid : req1_valid;
  assign otherState = isOne ? GRANT0 : GRANT1;
  assign countInc   = {1'b0, count_q} + 9'd1;

  assign sel       = isOne;
  assign grant     = {state_q == GRANT1, state_q == GRANT0};
  assign out_valid = outValid_q;
  assign out_data  = outData_q;

  // The >= comparison lets a saturated lone-streamer hand over right after
  // its next beat once the other side starts waiting.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        count_d = 8'd0;
        if (req0_valid && req1_valid) state_d = lastGrant_q ? GRANT0 : GRANT1;
        else if (req0_valid)          state_d = GRANT0;
        else if (req1_valid)          state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!mineValid) begin
          lastGrant_d = isOne;
          count_d     = 8'd0;
          state_d     = otherValid ? otherState : IDLE;
        end else if (xfer) begin
          if ((countInc >= {1'b0, MAX_CNT}) && otherValid) begin
            state_d     = otherState;
            count_d     = 8'd0;
            lastGrant_d = isOne;
          end else if (countInc >= {1'b0, MAX_CNT}) begin
            count_d = MAX_CNT;
          end else begin
            count_d = countInc[7:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      count_q     <= 8'd0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      count_q     <= count_d;
      if (xfer) begin
        outValid_q <= 1'b1;
        outData_q  <= isOne ? req1_data : req0_data;
      end else if (out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

endmodule
